// File: rtl/mem_access_arbiter_pkg.sv
// Shared constants for the two-port memory access arbiter: FSM state
// encoding and requester port identifiers.
package mem_access_arbiter_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin select: a lone requester always wins, a tie goes to
// the port that was not granted last.
module rr_pick2
    import mem_access_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic valid,
    output logic winner
);

    logic w_tie;

    assign w_tie  = req0 & req1;
    assign valid  = req0 | req1;
    assign winner = w_tie ? ((last_gnt == PORT0) ? PORT1 : PORT0)
                          : (req1 ? PORT1 : PORT0);

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port synchronous
// memory: grants one port, drives one access, returns a one-cycle ack.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int WORD_WIDTH = 8,
    parameter int WORD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WORD_WIDTH-1:0] wdata0,
    input  logic [WORD_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_we_n,
    output logic [ADDR_WIDTH-1:0] mem_adrs,
    output logic [WORD_WIDTH-1:0] mem_d_in,
    input  logic [WORD_WIDTH-1:0] mem_q
);

    if (WORD_DEPTH != 2 ** ADDR_WIDTH) begin : g_depth_check
        $error("WORD_DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [1:0]            r_state;
    logic                  r_winner;
    logic                  r_wr;
    logic                  r_last_gnt;
    logic [WORD_WIDTH-1:0] r_rdata;
    logic                  r_we_n;
    logic [ADDR_WIDTH-1:0] r_adrs;
    logic [WORD_WIDTH-1:0] r_d_in;

    logic                  w_valid;
    logic                  w_winner;
    logic                  w_win_wr;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [WORD_WIDTH-1:0] w_win_wdata;

    rr_pick2 u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (r_last_gnt),
        .valid    (w_valid),
        .winner   (w_winner)
    );

    assign w_win_wr    = (w_winner == PORT1) ? wr1    : wr0;
    assign w_win_addr  = (w_winner == PORT1) ? addr1  : addr0;
    assign w_win_wdata = (w_winner == PORT1) ? wdata1 : wdata0;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_winner   <= PORT0;
            r_wr       <= 1'b0;
            r_last_gnt <= PORT1;
            r_rdata    <= '0;
            r_we_n     <= 1'b1;
            r_adrs     <= '0;
            r_d_in     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_winner <= w_winner;
                        r_wr     <= w_win_wr;
                        r_adrs   <= w_win_addr;
                        r_d_in   <= w_win_wdata;
                        r_we_n   <= ~w_win_wr;
                        r_state  <= ISSUE;
                    end else begin
                        r_we_n <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Strobe lasts exactly one cycle: memory has sampled it on this edge.
                    r_we_n  <= 1'b1;
                    r_state <= r_wr ? DONE : CAPTURE;
                end
                CAPTURE: begin
                    r_rdata <= mem_q;
                    r_state <= DONE;
                end
                DONE: begin
                    r_last_gnt <= r_winner;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack0     = (r_state == DONE) && (r_winner == PORT0);
    assign ack1     = (r_state == DONE) && (r_winner == PORT1);
    assign busy     = (r_state != IDLE);
    assign rdata    = r_rdata;
    assign mem_we_n = r_we_n;
    assign mem_adrs = r_adrs;
    assign mem_d_in = r_d_in;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized-plus-directed bench for mem_access_arbiter with an attached
// memory model and a transaction-level reference checked every cycle.
module tb_mem_access_arbiter;

    typedef struct packed {
        bit         p;
        bit         wr;
        logic [1:0] a;
        logic [7:0] d;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [1:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, busy, mem_we_n;
    logic [7:0] rdata, mem_d_in;
    logic [1:0] mem_adrs;
    logic [7:0] mem_q = '0;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int we_cnt = 0;
    bit checking = 1'b0;
    bit ack_log[$];

    mem_access_arbiter #(.ADDR_WIDTH(2), .WORD_WIDTH(8), .WORD_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .mem_we_n(mem_we_n), .mem_adrs(mem_adrs), .mem_d_in(mem_d_in),
        .mem_q(mem_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached single-port memory: active-low write, registered read.
    logic [7:0] mem [4];
    always @(posedge clk) begin
        if (!mem_we_n) mem[mem_adrs] <= mem_d_in;
        mem_q <= mem[mem_adrs];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: one access occupies a slot of 3 (write) or 4 (read)
    // cycles starting at the grant edge; age counts cycles since that edge.
    function automatic cmd_t pick_cmd(bit r0, bit r1, bit last, bit w0, bit w1,
                                      logic [1:0] a0, logic [1:0] a1,
                                      logic [7:0] d0, logic [7:0] d1);
        cmd_t c;
        c.p  = (r0 && r1) ? !last : r1;
        c.wr = c.p ? w1 : w0;
        c.a  = c.p ? a1 : a0;
        c.d  = c.p ? d1 : d0;
        return c;
    endfunction

    cmd_t       m_cmd;
    int         m_age;
    bit         m_last;
    logic [7:0] m_rdata, m_rval;
    logic [7:0] ref_mem [4];
    cmd_t       w_cmd;
    int         m_len;

    assign w_cmd = pick_cmd(req0, req1, m_last, wr0, wr1, addr0, addr1, wdata0, wdata1);
    assign m_len = m_cmd.wr ? 3 : 4;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cmd   <= '0;
            m_age   <= 0;
            m_last  <= 1'b1;
            m_rdata <= '0;
        end else if (m_age == 0) begin
            if (req0 || req1) begin
                m_cmd <= w_cmd;
                m_age <= 1;
                if (w_cmd.wr) ref_mem[w_cmd.a] <= w_cmd.d;
                else m_rval <= ref_mem[w_cmd.a];
            end
        end else if (m_age == m_len - 1) begin
            m_age  <= 0;
            m_last <= m_cmd.p;
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == m_len - 1 && !m_cmd.wr) m_rdata <= m_rval;
        end
    end

    always @(negedge clk) begin
        if (!mem_we_n) we_cnt <= we_cnt + 1;
        if (ack0) ack_log.push_back(1'b0);
        if (ack1) ack_log.push_back(1'b1);
        if (checking) begin
            check("busy", busy, m_age != 0);
            check("mem_we_n", mem_we_n, !(m_age == 1 && m_cmd.wr));
            check("ack0", ack0, m_age != 0 && m_age == m_len - 1 && !m_cmd.p);
            check("ack1", ack1, m_age != 0 && m_age == m_len - 1 && m_cmd.p);
            check("rdata", rdata, m_rdata);
            check("mem_adrs", mem_adrs, m_cmd.a);
            check("mem_d_in", mem_d_in, m_cmd.d);
        end
    end

    // Called just after a rising edge; returns after dropping req following ack.
    task automatic do_access(input bit p, input bit w, input logic [1:0] a,
                             input logic [7:0] d, output logic [7:0] rd, output int lat);
        int  t0;
        bit  got;
        if (p) begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
        t0 = cyc;
        got = 1'b0;
        rd = '0;
        lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (p ? ack1 : ack0) begin
                got = 1'b1;
                rd = rdata;
                lat = cyc - t0;
            end
        end
        if (!got) check("ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    logic [7:0] rd0, rd1;
    int         lat0, lat1, we_base;
    logic [7:0] sweep_exp [4];

    initial begin
        sweep_exp = '{8'h3C, 8'h3D, 8'h3E, 8'h3F};
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checking = 1'b1;

        // Contention: both write at once, port 0 wins the first tie.
        ack_log.delete();
        fork
            do_access(1'b0, 1'b1, 2'd1, 8'h11, rd0, lat0);
            do_access(1'b1, 1'b1, 2'd3, 8'h22, rd1, lat1);
        join
        check("contention_n", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            check("contention_first", ack_log[0], 0);
            check("contention_second", ack_log[1], 1);
        end
        do_access(1'b0, 1'b0, 2'd1, 8'h00, rd0, lat0);
        check("readback_a1", rd0, 8'h11);
        do_access(1'b0, 1'b0, 2'd3, 8'h00, rd0, lat0);
        check("readback_a3", rd0, 8'h22);

        // Fairness: 6 back-to-back reads of addr 0 from each port.
        do_access(1'b1, 1'b1, 2'd0, 8'h5C, rd1, lat1);
        ack_log.delete();
        fork
            for (int i = 0; i < 6; i++) begin
                do_access(1'b0, 1'b0, 2'd0, 8'h00, rd0, lat0);
                check("fair_rd0", rd0, 8'h5C);
            end
            for (int i = 0; i < 6; i++) begin
                do_access(1'b1, 1'b0, 2'd0, 8'h00, rd1, lat1);
                check("fair_rd1", rd1, 8'h5C);
            end
        join
        check("fair_n", ack_log.size(), 12);
        foreach (ack_log[i]) check("fair_order", ack_log[i], i % 2);

        // Single write then read with latency.
        we_base = we_cnt;
        do_access(1'b0, 1'b1, 2'd2, 8'hA5, rd0, lat0);
        check("wr_latency", lat0, 2);
        check("wr_strobes", we_cnt - we_base, 1);
        do_access(1'b0, 1'b0, 2'd2, 8'h00, rd0, lat0);
        check("rd_latency", lat0, 3);
        check("rd_value", rd0, 8'hA5);

        // Late arrival: req1 rises while port 0's read is in ISSUE.
        ack_log.delete();
        we_base = we_cnt;
        fork
            do_access(1'b0, 1'b0, 2'd2, 8'h00, rd0, lat0);
            begin
                @(posedge clk);
                #1;
                do_access(1'b1, 1'b0, 2'd2, 8'h00, rd1, lat1);
            end
        join
        check("late_order_n", ack_log.size(), 2);
        if (ack_log.size() == 2) check("late_order", {ack_log[0], ack_log[1]}, 2'b01);
        check("late_rd0", rd0, 8'hA5);
        check("late_rd1", rd1, 8'hA5);
        check("late_strobes", we_cnt - we_base, 0);

        // Full sweep.
        we_base = we_cnt;
        for (int a = 0; a < 4; a++) do_access(1'b1, 1'b1, 2'(a), 8'(a) ^ 8'h3C, rd1, lat1);
        check("sweep_strobes", we_cnt - we_base, 4);
        for (int a = 0; a < 4; a++) begin
            do_access(1'b0, 1'b0, 2'(a), 8'h00, rd0, lat0);
            check("sweep_rd", rd0, sweep_exp[a]);
        end

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            fork
                if ($urandom_range(0, 2) != 0)
                    do_access(1'b0, 1'($urandom), 2'($urandom), 8'($urandom), rd0, lat0);
                if ($urandom_range(0, 2) != 0)
                    do_access(1'b1, 1'($urandom), 2'($urandom), 8'($urandom), rd1, lat1);
            join
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset during CAPTURE: no ack, immediate return to reset values.
        @(posedge clk);
        #1;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 2'd1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        ack_log.delete();
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_we_n", mem_we_n, 1);
        check("rst_acks", {ack0, ack1}, 2'b00);
        check("rst_rdata", rdata, 0);
        check("rst_adrs", mem_adrs, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_no_ack", ack_log.size(), 0);
        fork
            do_access(1'b0, 1'b0, 2'd1, 8'h00, rd0, lat0);
            do_access(1'b1, 1'b0, 2'd3, 8'h00, rd1, lat1);
        join
        check("post_rst_n", ack_log.size(), 2);
        if (ack_log.size() >= 1) check("post_rst_first", ack_log[0], 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
